player_car_mover: RTL and testbench



---
 rtl/game_pkg.sv | 38 +++
 rtl/rate_tick_gen.sv | 28 ++
 rtl/player_car_mover.sv | 111 +++++++++++
 tb/tb_player_car_mover.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared playfield geometry, coordinate widths and mover state encoding.
// The axis helper performs one clamped step on an 11-bit intermediate.
package game_pkg;

  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int CAR_W    = 20;
  localparam int CAR_H    = 20;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FROZEN,
    FINISHED
  } mover_state_t;

  // inc/dec both or neither -> no motion; never wraps below 0 or past hi
  function automatic logic [10:0] step_axis(
    input logic [10:0] pos,
    input logic        inc,
    input logic        dec,
    input logic [10:0] amount,
    input logic [10:0] hi
  );
    logic [10:0] sum;
    sum = pos + amount;
    if (inc && !dec) begin
      step_axis = (sum > hi) ? hi : sum;
    end else if (dec && !inc) begin
      step_axis = (pos < amount) ? 11'd0 : (pos - amount);
    end else begin
      step_axis = pos;
    end
  endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Free-running divider: tick is high combinationally on the last count of each DIV-cycle period.
// Holds while enable is low; clear (or reset) returns the count to 0.
module rate_tick_gen #(
  parameter int DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/player_car_mover.sv
// Player car position writer: steps the car per motion tick from buttons, clamped to the playfield.
// Position and step update on the edge ending a tick cycle; respawn > freeze > start/tick.
module player_car_mover
  import game_pkg::*;
#(
  parameter int TICK_DIV = 833333,
  parameter int STEP     = 2,
  parameter int X_START  = 20,
  parameter int Y_START  = 240,
  parameter int X_MAX    = SCREEN_W - CAR_W - 1,
  parameter int Y_MAX    = SCREEN_H - CAR_H - 1,
  parameter int FINISH_X = 600
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           freeze,
  input  logic           respawn,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           btn_up,
  input  logic           btn_down,
  output logic [X_W-1:0] current_x,
  output logic [Y_W-1:0] current_y,
  output logic           step,
  output logic           at_finish
);

  localparam logic [X_W-1:0] X_INIT   = X_W'(X_START);
  localparam logic [Y_W-1:0] Y_INIT   = Y_W'(Y_START);
  localparam logic [10:0]    STEP_AMT = 11'(STEP);
  localparam logic [10:0]    X_HI     = 11'(X_MAX);
  localparam logic [10:0]    Y_HI     = 11'(Y_MAX);
  localparam logic [10:0]    X_FIN    = 11'(FINISH_X);

  mover_state_t   state, state_nxt;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic           step_nxt;
  logic           tick;
  logic           tick_en;
  logic [10:0]    mv_x;
  logic [10:0]    mv_y;

  assign tick_en = (state == RUN) && !freeze;

  rate_tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (respawn),
    .enable (tick_en),
    .tick   (tick)
  );

  assign mv_x = step_axis({1'b0, current_x}, btn_right, btn_left, STEP_AMT, X_HI);
  assign mv_y = step_axis({2'b00, current_y}, btn_down, btn_up, STEP_AMT, Y_HI);

  always_comb begin
    state_nxt = state;
    x_nxt     = current_x;
    y_nxt     = current_y;
    step_nxt  = 1'b0;
    if (respawn) begin
      state_nxt = IDLE;
      x_nxt     = X_INIT;
      y_nxt     = Y_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (start && !freeze) state_nxt = RUN;
        end
        RUN: begin
          if (freeze) begin
            state_nxt = FROZEN;
          end else if (tick) begin
            x_nxt    = mv_x[X_W-1:0];
            y_nxt    = mv_y[Y_W-1:0];
            // a tick pinned against a wall moves nothing and must not pulse step
            step_nxt = (mv_x != {1'b0, current_x}) || (mv_y != {2'b00, current_y});
            if (mv_x >= X_FIN) state_nxt = FINISHED;
          end
        end
        FROZEN: begin
          if (!freeze) state_nxt = RUN;
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      current_x <= X_INIT;
      current_y <= Y_INIT;
      step      <= 1'b0;
    end else begin
      state     <= state_nxt;
      current_x <= x_nxt;
      current_y <= y_nxt;
      step      <= step_nxt;
    end
  end

  assign at_finish = (state == FINISHED);

endmodule

// File: tb/tb_player_car_mover.sv
// Randomized and directed bench for two mover instances against a cycle-level reference model
// fed through per-instance scoreboards.
module tb_player_car_mover;

  localparam int DIV = 4;

  typedef struct {
    int x;
    int y;
    int stp;
    int fin;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start, freeze, respawn, bl, br, bu, bd;

  logic [9:0] a_x, b_x;
  logic [8:0] a_y, b_y;
  logic       a_step, b_step, a_fin, b_fin;

  exp_t qa[$];
  exp_t qb[$];

  int xs[2] = '{20, 1};
  int ys[2] = '{240, 458};
  int mx[2], my[2], mcnt[2], mmode[2], mstep[2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  player_car_mover #(.TICK_DIV(DIV), .STEP(2), .X_START(20), .Y_START(240),
                     .X_MAX(619), .Y_MAX(459), .FINISH_X(600)) dut_a (
    .clk(clk), .reset(reset), .start(start), .freeze(freeze), .respawn(respawn),
    .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd),
    .current_x(a_x), .current_y(a_y), .step(a_step), .at_finish(a_fin)
  );

  player_car_mover #(.TICK_DIV(DIV), .STEP(2), .X_START(1), .Y_START(458),
                     .X_MAX(619), .Y_MAX(459), .FINISH_X(600)) dut_b (
    .clk(clk), .reset(reset), .start(start), .freeze(freeze), .respawn(respawn),
    .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd),
    .current_x(b_x), .current_y(b_y), .step(b_step), .at_finish(b_fin)
  );

  function automatic void chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
    end
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Modes: 0 idle, 1 run, 2 frozen, 3 finished
  function automatic void model_step(input int i);
    int dx, dy, nx, ny;
    if (reset || respawn) begin
      mx[i] = xs[i]; my[i] = ys[i]; mcnt[i] = 0; mmode[i] = 0; mstep[i] = 0;
    end else begin
      mstep[i] = 0;
      case (mmode[i])
        0: if (start && !freeze) mmode[i] = 1;
        1: begin
          if (freeze) mmode[i] = 2;
          else if (mcnt[i] == DIV - 1) begin
            mcnt[i] = 0;
            dx = int'(br) - int'(bl);
            dy = int'(bd) - int'(bu);
            nx = clampi(mx[i] + 2 * dx, 619);
            ny = clampi(my[i] + 2 * dy, 459);
            mstep[i] = ((nx != mx[i]) || (ny != my[i])) ? 1 : 0;
            mx[i] = nx;
            my[i] = ny;
            if (nx >= 600) mmode[i] = 3;
          end else mcnt[i]++;
        end
        2: if (!freeze) mmode[i] = 1;
        default: ;
      endcase
    end
  endfunction

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      model_step(i);
      e.x = mx[i]; e.y = my[i]; e.stp = mstep[i]; e.fin = (mmode[i] == 3) ? 1 : 0;
      if (i == 0) qa.push_back(e); else qb.push_back(e);
    end
    #1;
  endtask

  task automatic set_in(input logic st, input logic fr, input logic rs,
                        input logic l, input logic r, input logic u, input logic d);
    start = st; freeze = fr; respawn = rs; bl = l; br = r; bu = u; bd = d;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_x", int'(a_x), e.x);
        chk("a_y", int'(a_y), e.y);
        chk("a_step", int'(a_step), e.stp);
        chk("a_fin", int'(a_fin), e.fin);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_x", int'(b_x), e.x);
        chk("b_y", int'(b_y), e.y);
        chk("b_step", int'(b_step), e.stp);
        chk("b_fin", int'(b_fin), e.fin);
      end
    end
  end

  initial begin : stim
    logic [3:0] btns;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    run(2);
    chk("rst_x", int'(a_x), 20);
    chk("rst_y", int'(a_y), 240);
    reset = 1'b0;

    set_in(0, 0, 0, 0, 1, 0, 0);
    run(3);
    set_in(1, 0, 0, 0, 1, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 1, 0, 0);
    run(12);
    chk("right3_x", int'(a_x), 26);

    set_in(0, 0, 0, 1, 1, 0, 0);
    run(8);
    set_in(0, 0, 0, 0, 0, 1, 1);
    run(8);
    chk("cancel_x", int'(a_x), 26);

    set_in(0, 0, 1, 0, 0, 0, 0);
    cyc();
    set_in(1, 0, 0, 0, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 1, 0, 0, 1);
    run(12);
    chk("wall_bx", int'(b_x), 0);
    chk("wall_by", int'(b_y), 459);
    chk("diag_ax", int'(a_x), 14);
    chk("diag_ay", int'(a_y), 246);

    set_in(0, 0, 0, 0, 0, 0, 1);
    run(2);
    set_in(0, 1, 0, 0, 0, 0, 1);
    run(10);
    set_in(0, 0, 0, 0, 0, 0, 1);
    run(10);

    set_in(0, 0, 1, 0, 0, 0, 0);
    cyc();
    set_in(1, 0, 0, 0, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 1, 0, 0);
    run(1200);
    chk("finish_x", int'(a_x), 600);
    chk("finish_flag", int'(a_fin), 1);

    set_in(1, 0, 1, 0, 1, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 1, 0, 0);
    run(8);
    chk("respawn_x", int'(a_x), 20);
    chk("respawn_fin", int'(a_fin), 0);

    btns = 4'b0000;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) btns = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) freeze = ~freeze;
      start   = ($urandom_range(0, 19) == 0);
      respawn = ($urandom_range(0, 299) == 0);
      reset   = ($urandom_range(0, 999) == 0);
      {bl, br, bu, bd} = btns;
      cyc();
    end
    reset = 1'b0;

    @(negedge clk);
    #1;
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
